f1_race_controller: RTL

Sequencer for the F1 start-light game. It owns the timing of the light bar: one light is added per tick until all are lit, then a pseudo-random hold elapses, then all lights go out and the player's reaction time is measured in clock cycles. It replaces the free-running clock-divided light FSM at the top of the game design. It drives the LED bar directly and reports either a reaction time or a jump start.

---
 rtl/f1_pkg.sv | 20 ++
 rtl/f1_lfsr.sv | 21 ++
 rtl/f1_race_controller.sv | 121 ++++++++++++
 3 files changed

// File: rtl/f1_pkg.sv
// Shared types and constants for the F1 start-light sequencer.
package f1_pkg;

    localparam int N_WIDTH_DEF = 16;
    localparam int D_WIDTH_DEF = 8;
    localparam int L_WIDTH_DEF = 7;
    localparam int T_WIDTH_DEF = 16;

    // x^7 + x^3 + 1 on a left-shifting register: feedback from bits 6 and 2
    localparam logic [L_WIDTH_DEF-1:0] LFSR_TAPS = 7'b100_0100;

    typedef enum logic [2:0] {
        IDLE,
        LIGHTS,
        HOLD,
        REACT,
        WAIT_REL
    } state_t;

endpackage

// File: rtl/f1_lfsr.sv
// Free-running Fibonacci LFSR; seeded with 1 so it never reaches the all-zero lock-up state.
module f1_lfsr
    import f1_pkg::*;
#(
    parameter int                 L_WIDTH = L_WIDTH_DEF,
    parameter logic [L_WIDTH-1:0] TAPS    = L_WIDTH'(LFSR_TAPS)
) (
    input  logic               clk,
    input  logic               rst,
    output logic [L_WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= L_WIDTH'(1);
        end else begin
            q <= {q[L_WIDTH-2:0], ^(q & TAPS)};
        end
    end

endmodule

// File: rtl/f1_race_controller.sv
// Start-light sequencer: ramps the light bar, holds for a random number of ticks,
// then measures reaction time or flags a jump start.
module f1_race_controller
    import f1_pkg::*;
#(
    parameter int N_WIDTH = N_WIDTH_DEF,
    parameter int D_WIDTH = D_WIDTH_DEF,
    parameter int L_WIDTH = L_WIDTH_DEF,
    parameter int T_WIDTH = T_WIDTH_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               trigger,
    input  logic [N_WIDTH-1:0] N,
    output logic [D_WIDTH-1:0] data_out,
    output logic               busy,
    output logic               react_valid,
    output logic [T_WIDTH-1:0] react_time,
    output logic               jump_start
);

    state_t             state;
    state_t             state_next;
    logic [N_WIDTH-1:0] tick_cnt;
    logic [L_WIDTH-1:0] hold_cnt;
    logic [T_WIDTH-1:0] react_cnt;
    logic [L_WIDTH-1:0] lfsr_q;
    logic               armed;
    logic               in_sequence;
    logic               tick;
    logic               early_press;
    logic               last_light;
    logic               lights_out;

    f1_lfsr #(.L_WIDTH(L_WIDTH)) u_lfsr (
        .clk (clk),
        .rst (rst),
        .q   (lfsr_q)
    );

    assign in_sequence = (state == LIGHTS) || (state == HOLD);
    assign tick        = in_sequence && (tick_cnt == '0);
    // The press that started the round is still held on entry; only count one after a release.
    assign early_press = in_sequence && trigger && armed;
    // The bar is a thermometer code, so bit D-2 set means this tick lights the final lamp.
    assign last_light  = tick && (state == LIGHTS) && data_out[D_WIDTH-2];
    assign lights_out  = tick && (state == HOLD) && (hold_cnt == L_WIDTH'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        state_next = state;
        busy       = (state != IDLE);
        case (state)
            IDLE:     if (trigger) state_next = LIGHTS;
            LIGHTS:   if (early_press) state_next = WAIT_REL;
                      else if (last_light) state_next = HOLD;
            HOLD:     if (early_press) state_next = WAIT_REL;
                      else if (lights_out) state_next = REACT;
            REACT:    if (trigger) state_next = WAIT_REL;
            WAIT_REL: if (!trigger) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out    <= '0;
            react_valid <= 1'b0;
            react_time  <= '0;
            jump_start  <= 1'b0;
            tick_cnt    <= '0;
            hold_cnt    <= '0;
            react_cnt   <= '0;
            armed       <= 1'b0;
        end else begin
            react_valid <= 1'b0;
            jump_start  <= 1'b0;
            case (state)
                IDLE: begin
                    if (trigger) begin
                        tick_cnt <= N;
                        armed    <= 1'b0;
                    end
                end
                LIGHTS, HOLD: begin
                    if (!trigger) armed <= 1'b1;
                    tick_cnt <= tick ? N : tick_cnt - N_WIDTH'(1);
                    if (early_press) begin
                        data_out   <= '0;
                        jump_start <= 1'b1;
                    end else if (tick && state == LIGHTS) begin
                        data_out <= {data_out[D_WIDTH-2:0], 1'b1};
                        if (last_light) hold_cnt <= lfsr_q;
                    end else if (lights_out) begin
                        data_out  <= '0;
                        react_cnt <= '0;
                    end else if (tick) begin
                        hold_cnt <= hold_cnt - L_WIDTH'(1);
                    end
                end
                REACT: begin
                    if (react_cnt != '1) react_cnt <= react_cnt + T_WIDTH'(1);
                    if (trigger) begin
                        react_time  <= react_cnt;
                        react_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
